// File: rtl/alarm_pkg.sv
// Shared state encoding and helpers for the alarm zone controller.
package alarm_pkg;

  localparam logic [2:0] CODE_DISARMED    = 3'd0;
  localparam logic [2:0] CODE_EXIT_DELAY  = 3'd1;
  localparam logic [2:0] CODE_ARMED       = 3'd2;
  localparam logic [2:0] CODE_ENTRY_DELAY = 3'd3;
  localparam logic [2:0] CODE_ALARM       = 3'd4;

  typedef enum logic [2:0] {
    ST_DISARMED    = CODE_DISARMED,
    ST_EXIT_DELAY  = CODE_EXIT_DELAY,
    ST_ARMED       = CODE_ARMED,
    ST_ENTRY_DELAY = CODE_ENTRY_DELAY,
    ST_ALARM       = CODE_ALARM
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_delay_timer.sv
// Saturating down-counter shared by the exit, entry and siren phases.
module alarm_delay_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // A phase loaded with N reaches 1 on its Nth cycle, which is its last.
  assign expired = ((count >> 1) == '0);

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Zoned intruder-alarm controller with exit/entry delays and timed siren.
// Optional tamper input enabled by defining TAMPER_EN.
module alarm_zone_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_ZONES    = 4,
  parameter int EXIT_CYCLES  = 16,
  parameter int ENTRY_CYCLES = 16,
  parameter int ALARM_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [NUM_ZONES-1:0] sensor,
  input  logic [NUM_ZONES-1:0] zone_en,
  input  logic [NUM_ZONES-1:0] instant,
`ifdef TAMPER_EN
  input  logic                 tamper,
`endif
  output logic                 alarm,
  output logic [2:0]           state,
  output logic                 arm_fail,
  output logic [NUM_ZONES-1:0] zone_latch
);

  localparam int TW = $clog2(max3(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES) + 1);

  state_e               state_q;
  state_e               state_d;
  state_e               rearm_state;
  logic [NUM_ZONES-1:0] viol;
  logic [NUM_ZONES-1:0] latch_d;
  logic                 arm_fail_d;
  logic                 timer_load;
  logic                 timer_expired;
  logic [TW-1:0]        timer_val;

`ifdef TAMPER_EN
  logic tamper_q;
  logic tamper_d;

  // A siren raised by tamper falls back to disarmed rather than re-arming.
  assign rearm_state = tamper_q ? ST_DISARMED : ST_ARMED;
  assign tamper_d    = (state_d == ST_ALARM) && (tamper_q || tamper);
`else
  assign rearm_state = ST_ARMED;
`endif

  assign viol = sensor & zone_en;

  always_comb begin
    state_d    = state_q;
    arm_fail_d = 1'b0;
    latch_d    = zone_latch;
    timer_load = 1'b0;
    if (state_q == ST_ARMED || state_q == ST_ENTRY_DELAY || state_q == ST_ALARM)
      latch_d = zone_latch | viol;
    if (disarm) begin
      state_d = ST_DISARMED;
`ifdef TAMPER_EN
    end else if (tamper) begin
      state_d    = ST_ALARM;
      timer_load = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            if (viol == '0) begin
              state_d = ST_EXIT_DELAY;
              latch_d = '0;
            end else begin
              arm_fail_d = 1'b1;
            end
          end
        end
        ST_EXIT_DELAY: begin
          if (timer_expired) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if ((viol & instant) != '0) state_d = ST_ALARM;
          else if (viol != '0)        state_d = ST_ENTRY_DELAY;
        end
        ST_ENTRY_DELAY: begin
          if (((viol & instant) != '0) || timer_expired) state_d = ST_ALARM;
        end
        ST_ALARM: begin
          if (timer_expired) state_d = rearm_state;
        end
        default: state_d = ST_DISARMED;
      endcase
    end
    if (state_d != state_q) timer_load = 1'b1;
  end

  always_comb begin
    timer_val = '0;
    case (state_d)
      ST_EXIT_DELAY:  timer_val = TW'(EXIT_CYCLES);
      ST_ENTRY_DELAY: timer_val = TW'(ENTRY_CYCLES);
      ST_ALARM:       timer_val = TW'(ALARM_CYCLES);
      default:        timer_val = '0;
    endcase
  end

  alarm_delay_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DISARMED;
      arm_fail   <= 1'b0;
      zone_latch <= '0;
`ifdef TAMPER_EN
      tamper_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      arm_fail   <= arm_fail_d;
      zone_latch <= latch_d;
`ifdef TAMPER_EN
      tamper_q   <= tamper_d;
`endif
    end
  end

  // Siren is a pure decode of the registered state.
  assign alarm = (state_q == ST_ALARM);
  assign state = state_q;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Scoreboard bench for alarm_zone_ctrl: directed scenarios then randomized traffic
// against a cycle-level reference model of the alarm rules.
module tb_alarm_zone_ctrl;

  localparam int NZ      = 4;
  localparam int EXIT_C  = 4;
  localparam int ENTRY_C = 3;
  localparam int ALARM_C = 8;
  localparam logic [NZ-1:0] ALL  = 4'b1111;
  localparam logic [NZ-1:0] NONE = 4'b0000;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          arm     = 1'b0;
  logic          disarm  = 1'b0;
  logic [NZ-1:0] sensor  = '0;
  logic [NZ-1:0] zone_en = '0;
  logic [NZ-1:0] instant = '0;
  logic          alarm;
  logic [2:0]    state;
  logic          arm_fail;
  logic [NZ-1:0] zone_latch;
`ifdef TAMPER_EN
  logic          tamper  = 1'b0;
`endif

  typedef struct {
    logic [2:0]    st;
    logic          al;
    logic          af;
    logic [NZ-1:0] zl;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode 0..4, cycles already spent in the mode, sticky zones.
  int            m_mode = 0;
  int            m_age  = 0;
  logic [NZ-1:0] m_latch = '0;

  always #5 clk = ~clk;

  alarm_zone_ctrl #(
    .NUM_ZONES    (NZ),
    .EXIT_CYCLES  (EXIT_C),
    .ENTRY_CYCLES (ENTRY_C),
    .ALARM_CYCLES (ALARM_C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .disarm     (disarm),
    .sensor     (sensor),
    .zone_en    (zone_en),
    .instant    (instant),
`ifdef TAMPER_EN
    .tamper     (tamper),
`endif
    .alarm      (alarm),
    .state      (state),
    .arm_fail   (arm_fail),
    .zone_latch (zone_latch)
  );

  function automatic int dwell(input int mode);
    case (mode)
      1:       return EXIT_C;
      3:       return ENTRY_C;
      4:       return ALARM_C;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.st = 3'd0;
    e.al = 1'b0;
    e.af = 1'b0;
    e.zl = '0;
    return e;
  endfunction

  function automatic void model_reset();
    m_mode  = 0;
    m_age   = 0;
    m_latch = '0;
  endfunction

  function automatic exp_t model_step(input logic a, input logic d,
                                      input logic [NZ-1:0] s, input logic [NZ-1:0] en,
                                      input logic [NZ-1:0] inst);
    logic [NZ-1:0] v;
    int            nxt;
    logic          fail;
    logic          done;
    exp_t          e;
    v    = s & en;
    nxt  = m_mode;
    fail = 1'b0;
    done = (m_age + 1 >= dwell(m_mode));
    if (m_mode >= 2 && m_mode <= 4) m_latch = m_latch | v;
    if (d) begin
      nxt = 0;
    end else begin
      case (m_mode)
        0: if (a) begin
             if (v == '0) begin
               nxt     = 1;
               m_latch = '0;
             end else begin
               fail = 1'b1;
             end
           end
        1: if (done) nxt = 2;
        2: if ((v & inst) != '0) nxt = 4; else if (v != '0) nxt = 3;
        3: if (((v & inst) != '0) || done) nxt = 4;
        4: if (done) nxt = 2;
        default: nxt = 0;
      endcase
    end
    m_age  = (nxt == m_mode) ? m_age + 1 : 0;
    m_mode = nxt;
    e.st = nxt[2:0];
    e.al = (nxt == 4);
    e.af = fail;
    e.zl = m_latch;
    return e;
  endfunction

  task automatic apply_stimulus(input logic a, input logic d, input logic [NZ-1:0] s,
                                input logic [NZ-1:0] en, input logic [NZ-1:0] inst);
    @(negedge clk);
    rst_n   = 1'b1;
    arm     = a;
    disarm  = d;
    sensor  = s;
    zone_en = en;
    instant = inst;
    exp_q.push_back(model_step(a, d, s, en, inst));
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    arm    = 1'b0;
    disarm = 1'b0;
    sensor = '0;
    model_reset();
    exp_q.push_back(zero_exp());
  endtask

  // Drops reset between clock edges: one check right away, one at the next edge.
  task automatic pulse_async_reset();
    @(negedge clk);
    #2;
    model_reset();
    exp_q.push_back(zero_exp());
    exp_q.push_back(zero_exp());
    rst_n = 1'b0;
  endtask

  task automatic check_field(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field("state",      32'(state),      32'(e.st));
    check_field("alarm",      32'(alarm),      32'(e.al));
    check_field("arm_fail",   32'(arm_fail),   32'(e.af));
    check_field("zone_latch", 32'(zone_latch), 32'(e.zl));
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  initial begin
    logic [NZ-1:0] r_en;
    logic [NZ-1:0] r_inst;
    logic [NZ-1:0] r_s;
    logic          r_a;
    logic          r_d;

    hold_reset();
    hold_reset();
    apply_stimulus(1'b0, 1'b0, NONE, ALL, NONE);

    $display("[TB] clean arm and exit delay");
    apply_stimulus(1'b1, 1'b0, NONE, ALL, NONE);
    repeat (6) apply_stimulus(1'b0, 1'b0, NONE, ALL, NONE);
    apply_stimulus(1'b0, 1'b1, NONE, ALL, NONE);

    $display("[TB] arm refused, then accepted with zone masked");
    apply_stimulus(1'b1, 1'b0, 4'b0010, ALL, NONE);
    apply_stimulus(1'b0, 1'b0, NONE, ALL, NONE);
    apply_stimulus(1'b1, 1'b0, 4'b0010, 4'b1101, NONE);
    repeat (5) apply_stimulus(1'b0, 1'b0, 4'b0010, 4'b1101, NONE);

    $display("[TB] entry delay then siren and auto-rearm");
    apply_stimulus(1'b0, 1'b0, 4'b0001, ALL, NONE);
    repeat (13) apply_stimulus(1'b0, 1'b0, NONE, ALL, NONE);

    $display("[TB] instant zone during entry delay");
    apply_stimulus(1'b0, 1'b0, 4'b0001, ALL, NONE);
    apply_stimulus(1'b0, 1'b0, 4'b1000, ALL, 4'b1000);
    repeat (2) apply_stimulus(1'b0, 1'b0, NONE, ALL, NONE);

    $display("[TB] disarm beats arm during siren");
    apply_stimulus(1'b1, 1'b1, NONE, ALL, NONE);
    repeat (2) apply_stimulus(1'b0, 1'b0, NONE, ALL, NONE);

    $display("[TB] asynchronous reset during exit delay");
    apply_stimulus(1'b1, 1'b0, NONE, ALL, NONE);
    apply_stimulus(1'b0, 1'b0, NONE, ALL, NONE);
    pulse_async_reset();
    repeat (3) apply_stimulus(1'b0, 1'b0, NONE, ALL, NONE);

    $display("[TB] randomized traffic");
    r_en   = ALL;
    r_inst = NONE;
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) begin
        r_en   = NZ'($urandom) | NZ'($urandom);
        r_inst = NZ'($urandom) & NZ'($urandom);
      end
      r_s = NZ'($urandom) & NZ'($urandom) & NZ'($urandom);
      r_a = ($urandom_range(0, 5) == 0);
      r_d = ($urandom_range(0, 29) == 0);
      apply_stimulus(r_a, r_d, r_s, r_en, r_inst);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_zone_ctrl.md
ALARM_ZONE_CTRL -- requirements
Module: alarm_zone_ctrl

Interface
REQ-001 Parameter NUM_ZONES, default 4: number of sensor zones, 1..16.
REQ-002 Parameter EXIT_CYCLES, default 16: exit-delay length in clk cycles, at least 1.
REQ-003 Parameter ENTRY_CYCLES, default 16: entry-delay length in clk cycles, at least 1.
REQ-004 Parameter ALARM_CYCLES, default 64: siren duration before auto-rearm, at least 1.
REQ-005 clk, input, 1: clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-006 rst_n, input, 1: asynchronous active-low reset.
REQ-007 arm, input, 1: arm request, sampled every cycle.
REQ-008 disarm, input, 1: disarm request, sampled every cycle.
REQ-009 sensor, input, NUM_ZONES: zone sensor levels; 1 = violated.
REQ-010 zone_en, input, NUM_ZONES: per-zone enable; disabled zones are ignored everywhere.
REQ-011 instant, input, NUM_ZONES: per-zone instant flag; the zone bypasses the entry delay.
REQ-012 alarm, output, 1: siren drive.
REQ-013 state, output, 3: current FSM state encoding.
REQ-014 arm_fail, output, 1: one-cycle pulse; an arm request was refused.
REQ-015 zone_latch, output, NUM_ZONES: sticky record of violated zones.

Function
REQ-016 Let viol = sensor & zone_en; states SHALL be DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4; all other codes SHALL return to DISARMED on the next cycle.
REQ-017 DISARMED + arm + viol==0 SHALL move to EXIT_DELAY; DISARMED + arm + viol!=0 SHALL stay DISARMED and pulse arm_fail for exactly 1 cycle.
REQ-018 EXIT_DELAY SHALL last exactly EXIT_CYCLES cycles, then go to ARMED; sensors are ignored during EXIT_DELAY.
REQ-019 ARMED with (viol & instant)!=0 SHALL go to ALARM; otherwise viol!=0 SHALL go to ENTRY_DELAY.
REQ-020 ENTRY_DELAY SHALL last exactly ENTRY_CYCLES cycles, then go to ALARM; an instant-zone violation during ENTRY_DELAY SHALL go to ALARM immediately.
REQ-021 ALARM SHALL last exactly ALARM_CYCLES cycles, then go to ARMED (auto-rearm).
REQ-022 disarm SHALL move any state to DISARMED on the next clock edge and SHALL take priority over arm, sensors and timer expiry in the same cycle.
REQ-023 arm SHALL be ignored in every state except DISARMED.
REQ-024 alarm SHALL equal (state==ALARM), decoded from registered state only, with no combinational path from any input.
REQ-025 zone_latch SHALL OR in viol each cycle while state is ARMED, ENTRY_DELAY or ALARM.
REQ-026 zone_latch SHALL clear only on the cycle an arm request is accepted, and SHALL hold its value through DISARMED.
REQ-027 The delay timer SHALL be a down-counter of width clog2(max(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES)+1).
REQ-028 The timer SHALL load on every state entry and SHALL never wrap below zero.

Reset
REQ-029 While rst_n is low: state=DISARMED, alarm=0, arm_fail=0, zone_latch=0, timer=0.
REQ-030 Reset asserted mid-delay or mid-alarm SHALL abort immediately with no residual pulse.

Configuration
REQ-031 With TAMPER_EN defined, a port tamper (input, 1) SHALL force ALARM from any state, including DISARMED, on the next edge; disarm still wins.
REQ-032 Tamper-triggered ALARM SHALL expire to DISARMED, not ARMED.
REQ-033 Without TAMPER_EN, the tamper port and its logic SHALL be absent.

Structure
REQ-034 Package alarm_pkg SHALL hold the state enum and the state-code localparams.
REQ-035 Sub-module alarm_delay_timer SHALL implement load/count-down/expire and be instantiated once.

Verification (NUM_ZONES=4, EXIT=4, ENTRY=3, ALARM=8)
REQ-036 Arm with sensor=0000 -> state 1 for 4 cycles, then 2; arm_fail stays 0.
REQ-037 Arm with sensor=0010, zone_en=1111 -> state stays 0, one arm_fail pulse; with zone_en=1101 -> arm accepted.
REQ-038 ARMED, sensor=0001, instant=0000 -> state 3 for 3 cycles, then 4; alarm=1 for 8 cycles, then state 2; zone_latch=0001.
REQ-039 ENTRY_DELAY, sensor=1000 with instant=1000 -> ALARM on the next edge; zone_latch=1001.
REQ-040 disarm and arm in the same cycle during ALARM -> state 0, alarm=0 next cycle; zone_latch retained.
REQ-041 rst_n pulsed low during EXIT_DELAY -> all outputs 0, state 0, asynchronously.
